// File: rtl/soc_bus_pkg.sv
// Shared bus types for the firmware BRAM path: arbiter state encoding, grant ids,
// request payload and the address range helper.
package soc_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [DATA_W-1:0] ERR_WORD_DFLT = 32'hDEAD_BEEF;

   localparam logic GRANT_M0 = 1'b0;
   localparam logic GRANT_M1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } bus_req_t;

   // Byte address is legal when its word index lies inside the BRAM.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                          input int unsigned       mem_words);
      logic [ADDR_W-1:0] word_idx;
      word_idx = addr >> 2;
      return word_idx < ADDR_W'(mem_words);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the master that was not granted last wins.
// Pure combinational; the caller registers the result.
module rr_arb2
   import soc_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == GRANT_M0) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/bram_arbiter.sv
// Two-master arbiter in front of the single-port firmware BRAM. Forces an idle slave
// cycle between transfers, rejects out-of-range addresses and bounds slave latency.
module bram_arbiter
   import soc_bus_pkg::*;
#(
   parameter int unsigned       MEM_WORDS      = 16384,
   parameter int unsigned       TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_WORD       = ERR_WORD_DFLT
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   output logic [DATA_W-1:0] m1_rdata,

   output logic              s_valid,
   input  logic              s_ready,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   input  logic [DATA_W-1:0] s_rdata,

   output logic              err_sticky,
   input  logic              err_clr
);

   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 2);

   arb_state_e          state_q, state_d;
   bus_req_t            s_req_q, s_req_d;
   logic                s_valid_q, s_valid_d;
   logic                grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                m0_ready_q, m0_ready_d;
   logic                m1_ready_q, m1_ready_d;
   logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
   logic                err_q, err_d;

   logic [1:0]          gnt_c;
   bus_req_t            req_c;
   logic                in_range_c;
   logic                timeout_c;
   logic                cmpl_c;
   logic                cmpl_err_c;
   logic                cmpl_gnt_c;
   logic [DATA_W-1:0]   cmpl_data_c;

   rr_arb2 u_rr_arb2 (
      .req        ({m1_valid, m0_valid}),
      .last_grant (last_grant_q),
      .gnt        (gnt_c)
   );

   always_comb begin
      req_c = gnt_c[1] ? bus_req_t'{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb}
                       : bus_req_t'{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
   end

   assign in_range_c = addr_in_range(req_c.addr, MEM_WORDS);
   assign timeout_c  = (timer_q == TIMER_W'(TIMEOUT_CYCLES));

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (|gnt_c) state_d = in_range_c ? ST_BUSY : ST_DONE;
         end
         ST_BUSY: begin
            if (s_ready || timeout_c) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; DONE ignores s_ready since it is the stale BRAM ready.
   always_comb begin
      s_req_d      = s_req_q;
      s_valid_d    = 1'b0;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      m0_ready_d   = 1'b0;
      m1_ready_d   = 1'b0;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      cmpl_c       = 1'b0;
      cmpl_err_c   = 1'b0;
      cmpl_gnt_c   = grant_q;
      cmpl_data_c  = s_rdata;

      case (state_q)
         ST_IDLE: begin
            if (|gnt_c) begin
               grant_d      = gnt_c[1];
               last_grant_d = gnt_c[1];
               s_req_d      = req_c;
               timer_d      = '0;
               if (in_range_c) begin
                  s_valid_d = 1'b1;
               end else begin
                  cmpl_c     = 1'b1;
                  cmpl_err_c = 1'b1;
                  cmpl_gnt_c = gnt_c[1];
               end
            end
         end
         ST_BUSY: begin
            s_valid_d = 1'b1;
            if (s_ready) begin
               cmpl_c = 1'b1;
            end else if (timeout_c) begin
               cmpl_c     = 1'b1;
               cmpl_err_c = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: ;
      endcase

      if (cmpl_c) begin
         s_valid_d = 1'b0;
         if (cmpl_err_c) cmpl_data_c = ERR_WORD;
         if (cmpl_gnt_c == GRANT_M1) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = cmpl_data_c;
         end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = cmpl_data_c;
         end
      end

      if (cmpl_err_c)   err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;
      else              err_d = err_q;
   end

   // Output and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_req_q      <= '0;
         s_valid_q    <= 1'b0;
         grant_q      <= GRANT_M0;
         last_grant_q <= GRANT_M1;
         timer_q      <= '0;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         s_req_q      <= s_req_d;
         s_valid_q    <= s_valid_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         m0_ready_q   <= m0_ready_d;
         m1_ready_q   <= m1_ready_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
         err_q        <= err_d;
      end
   end

   assign s_valid    = s_valid_q;
   assign s_addr     = s_req_q.addr;
   assign s_wdata    = s_req_q.wdata;
   assign s_wstrb    = s_req_q.wstrb;
   assign m0_ready   = m0_ready_q;
   assign m1_ready   = m1_ready_q;
   assign m0_rdata   = m0_rdata_q;
   assign m1_rdata   = m1_rdata_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: a registered-ready BRAM slave plus a transaction-level model
// that predicts grant order, completion cycles, read data and the sticky error flag.
module tb_bram_arbiter;

   localparam int unsigned MEM_WORDS = 16384;
   localparam int unsigned TIMEOUT   = 255;
   localparam logic [31:0] ERR_WORD  = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_valid, m0_ready, m1_valid, m1_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        err_sticky, err_clr;

   bram_arbiter #(.MEM_WORDS(MEM_WORDS), .TIMEOUT_CYCLES(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .err_sticky(err_sticky), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h1234_5678;
      if (i == 8) return 32'h1122_3344;
      return {8'(i), 8'hA5, 8'(i * 7), 8'h3C};
   endfunction

   // BRAM slave: ready registered one cycle after any sampled valid, 64-word window.
   logic [31:0] bmem [64];
   bit          stall;
   bit          load_init;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_ready <= 1'b0;
         s_rdata <= 32'h0;
         if (load_init) for (int i = 0; i < 64; i++) bmem[i] <= init_word(i);
      end else begin
         s_ready <= 1'b0;
         if (s_valid && !stall) begin
            s_ready <= 1'b1;
            s_rdata <= bmem[s_addr[7:2]];
            for (int b = 0; b < 4; b++)
               if (s_wstrb[b]) bmem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
         end
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model state.
   logic [31:0] ref_mem [64];
   bit          pend [2];
   logic [31:0] q_addr [2];
   logic [31:0] q_wdata [2];
   logic [3:0]  q_wstrb [2];
   int          cyc = 0;
   bit          busy = 0;
   int          done_cyc = 0;
   int          free_cyc = 0;
   int          exp_m = 0;
   logic [31:0] exp_data;
   bit          exp_chk_data, exp_err_txn, exp_inr;
   bit          last_g = 1;
   bit          err_m = 0;
   bit          rand_en = 0;
   bit          clr_req = 0;
   int          act_log [$];

   task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      pend[m] = 1; q_addr[m] = a; q_wdata[m] = d; q_wstrb[m] = s;
   endtask

   task automatic drive();
      m0_valid = pend[0]; m0_addr = q_addr[0]; m0_wdata = q_wdata[0]; m0_wstrb = q_wstrb[0];
      m1_valid = pend[1]; m1_addr = q_addr[1]; m1_wdata = q_wdata[1]; m1_wstrb = q_wstrb[1];
   endtask

   task automatic gen(input int m);
      logic [31:0] a;
      int r = $urandom_range(0, 99);
      if (r < 6)       a = 32'h0001_0000 + 32'($urandom_range(0, 255));
      else if (r < 8)  a = 32'hFFFF_FFFC;
      else if (r < 12) a = 32'h0000_FFFC;
      else             a = 32'($urandom_range(0, 255));
      issue(m, a, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
   endtask

   // One cycle: check outputs of this cycle, then drive and predict the next.
   task automatic step();
      bit   r0, r1, sv, err_next;
      int   g, idx;
      logic [31:0] a, w;
      r0 = busy && done_cyc == cyc && exp_m == 0;
      r1 = busy && done_cyc == cyc && exp_m == 1;
      sv = busy && exp_inr && (cyc == done_cyc - 2 || cyc == done_cyc - 1);
      check("m0_ready", 32'(m0_ready), 32'(r0));
      check("m1_ready", 32'(m1_ready), 32'(r1));
      check("s_valid", 32'(s_valid), 32'(sv));
      check("err_sticky", 32'(err_sticky), 32'(err_m));
      if (m0_ready) act_log.push_back(0);
      if (m1_ready) act_log.push_back(1);
      if (busy && done_cyc == cyc) begin
         if (exp_chk_data) check(exp_m == 1 ? "m1_rdata" : "m0_rdata",
                                 exp_m == 1 ? m1_rdata : m0_rdata, exp_data);
         pend[exp_m] = 0;
         busy = 0;
         free_cyc = cyc + 1;
      end
      if (rand_en) for (int m = 0; m < 2; m++) if (!pend[m] && $urandom_range(0, 99) < 50) gen(m);
      drive();
      if (!busy && cyc >= free_cyc && (pend[0] || pend[1])) begin
         if (pend[0] && pend[1]) g = last_g ? 0 : 1;
         else                    g = pend[1] ? 1 : 0;
         last_g = (g == 1);
         exp_m = g;
         busy = 1;
         a = q_addr[g];
         idx = int'(a[7:2]);
         exp_inr = longint'(a) < longint'(MEM_WORDS) * 4;
         if (exp_inr) begin
            done_cyc = cyc + 3;
            exp_err_txn = 0;
            exp_data = ref_mem[idx];
            exp_chk_data = (q_wstrb[g] == 4'h0);
            w = ref_mem[idx];
            for (int b = 0; b < 4; b++) if (q_wstrb[g][b]) w[8*b +: 8] = q_wdata[g][8*b +: 8];
            ref_mem[idx] = w;
         end else begin
            done_cyc = cyc + 1;
            exp_err_txn = 1;
            exp_data = ERR_WORD;
            exp_chk_data = 1;
         end
      end
      err_clr = rand_en ? ($urandom_range(0, 15) == 0) : clr_req;
      err_next = (busy && exp_err_txn && done_cyc == cyc + 1) ? 1'b1 : (err_clr ? 1'b0 : err_m);
      err_m = err_next;
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || pend[0] || pend[1]) && n < 60) begin step(); n++; end
      check("drain_done", 32'(busy || pend[0] || pend[1]), 32'h0);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int n_busy, mark;
      bit got, bad;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      pend[0] = 0; pend[1] = 0;
      q_addr[0] = 0; q_addr[1] = 0; q_wdata[0] = 0; q_wdata[1] = 0;
      q_wstrb[0] = 0; q_wstrb[1] = 0;
      drive();
      err_clr = 0; stall = 0; load_init = 1; resetn = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      load_init = 0; resetn = 1;

      check("rst_s_valid", 32'(s_valid), 32'h0);
      check("rst_s_addr", s_addr, 32'h0);
      check("rst_s_wstrb", 32'(s_wstrb), 32'h0);
      check("rst_m0_rdata", m0_rdata, 32'h0);
      check("rst_m1_rdata", m1_rdata, 32'h0);

      // Single M0 read with fixed latency.
      issue(0, 32'h10, 32'h0, 4'h0);
      repeat (5) step();
      check("t1_rdata", m0_rdata, 32'h1234_5678);

      // Partial write by M1 then readback by M0.
      issue(1, 32'h20, 32'hAABB_CCDD, 4'b0100);
      repeat (5) step();
      issue(0, 32'h20, 32'h0, 4'h0);
      repeat (5) step();
      check("t3_rdata", m0_rdata, 32'h11BB_3344);

      // Out-of-range, sticky error, clear, then last legal word.
      issue(0, 32'h0001_0000, 32'h0, 4'h0);
      repeat (3) step();
      check("t4_err_set", 32'(err_sticky), 32'h1);
      check("t4_rdata", m0_rdata, ERR_WORD);
      clr_req = 1; step(); clr_req = 0; step();
      check("t4_err_clr", 32'(err_sticky), 32'h0);
      issue(0, 32'h0000_FFFC, 32'h0, 4'h0);
      repeat (5) step();

      // Continuous contention alternates grants.
      mark = act_log.size();
      for (int s = 0; s < 40; s++) begin
         if (!pend[0]) issue(0, 32'($urandom_range(0, 255)), $urandom, 4'h0);
         if (!pend[1]) issue(1, 32'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)));
         step();
      end
      drain();
      check("t2_count", 32'(act_log.size() - mark >= 8), 32'h1);
      for (int i = mark + 1; i < mark + 8 && i < act_log.size(); i++)
         check("t2_alternate", 32'(act_log[i] != act_log[i-1]), 32'h1);

      // Slave never answers: timeout completion.
      stall = 1;
      issue(0, 32'h10, 32'h0, 4'h0);
      drive();
      n_busy = 0; got = 0; bad = 0;
      for (int c = 0; c < int'(TIMEOUT) + 20 && !got; c++) begin
         @(negedge clk);
         if (s_valid) n_busy++;
         if (m1_ready) bad = 1;
         if (m0_ready) got = 1;
      end
      check("t5_ready_seen", 32'(got), 32'h1);
      check("t5_busy_window", 32'(n_busy >= int'(TIMEOUT) && n_busy <= int'(TIMEOUT) + 1), 32'h1);
      check("t5_no_m1_ready", 32'(bad), 32'h0);
      check("t5_rdata", m0_rdata, ERR_WORD);
      check("t5_err", 32'(err_sticky), 32'h1);
      pend[0] = 0; drive(); stall = 0;
      @(negedge clk);
      busy = 0; last_g = 0; err_m = 1; free_cyc = cyc;
      clr_req = 1; step(); clr_req = 0; step();

      // Reset while BUSY.
      drain();
      issue(0, 32'h14, 32'h0, 4'h0);
      step(); step();
      resetn = 0;
      #1;
      check("t6_s_valid_async", 32'(s_valid), 32'h0);
      pend[0] = 0; pend[1] = 0; drive();
      bad = 0;
      repeat (3) begin @(negedge clk); if (m0_ready || m1_ready || s_valid) bad = 1; end
      resetn = 1;
      busy = 0; last_g = 1; err_m = 0; free_cyc = cyc;
      repeat (2) begin @(negedge clk); if (m0_ready || m1_ready || s_valid) bad = 1; end
      check("t6_quiet", 32'(bad), 32'h0);
      mark = act_log.size();
      issue(0, 32'h18, 32'h0, 4'h0);
      issue(1, 32'h1C, 32'h0, 4'h0);
      repeat (10) step();
      check("t6_first_grant", act_log.size() > mark ? 32'(act_log[mark]) : 32'h9, 32'h0);

      // Random traffic with random error clears.
      rand_en = 1;
      repeat (1500) step();
      rand_en = 0;
      err_clr = 0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
